// File: rtl/lcd_pkg.sv
// Shared types and timing for the HD44780 4-bit write path.
// Timing constants assume a 50 MHz system clock.
package lcd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP_H,
        ST_PULSE_H,
        ST_HOLD_H,
        ST_GAP,
        ST_SETUP_L,
        ST_PULSE_L,
        ST_HOLD_L,
        ST_EXEC,
        ST_DONE
    } lcd_state_e;

    localparam int T_SETUP_DEF     = 2;
    localparam int T_PULSE_DEF     = 12;
    localparam int T_HOLD_DEF      = 1;
    localparam int T_GAP_DEF       = 50;
    localparam int T_EXEC_DEF      = 2000;
    localparam int T_EXEC_LONG_DEF = 82000;
    localparam int CNT_W_DEF       = 17;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear and Home are the only instructions needing the 1.64 ms wait.
    function automatic logic is_long_cmd(
        input logic [7:0] data,
        input logic       rs,
        input logic       nib
    );
        return !rs && !nib &&
               ((data == CMD_CLEAR) || (data == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Loadable down-counter shared by every timed phase of the write engine.
// Load wins over decrement; the count parks at zero and never wraps.
module lcd_delay_cnt #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/lcd_write_ctrl.sv
// HD44780 4-bit write engine: nibble/E-strobe sequencing plus the
// post-write execution wait, ending in a one-cycle wr_finish.
module lcd_write_ctrl
    import lcd_pkg::*;
#(
    parameter int T_SETUP     = T_SETUP_DEF,
    parameter int T_PULSE     = T_PULSE_DEF,
    parameter int T_HOLD      = T_HOLD_DEF,
    parameter int T_GAP       = T_GAP_DEF,
    parameter int T_EXEC      = T_EXEC_DEF,
    parameter int T_EXEC_LONG = T_EXEC_LONG_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_enable,
    input  logic [7:0] wr_data,
    input  logic       wr_rs,
    input  logic       wr_nibble,
    output logic       wr_finish,
    output logic       busy,
    output logic [3:0] lcd_d,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_GAP   = CNT_W'(T_GAP - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

    lcd_state_e       state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d;
    logic             nib_q, nib_d;
    logic [3:0]       lcd_d_q, lcd_d_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             lcd_e_q, lcd_e_d;
    logic             busy_q, busy_d;
    logic             fin_q, fin_d;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;
    logic [CNT_W-1:0] exec_val;

    lcd_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    assign exec_val = is_long_cmd(data_q, rs_q, nib_q) ? LD_LONG : LD_EXEC;

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        rs_d     = rs_q;
        nib_d    = nib_q;
        lcd_d_d  = lcd_d_q;
        lcd_rs_d = lcd_rs_q;
        busy_d   = busy_q;
        fin_d    = 1'b0;
        cnt_load = 1'b0;
        cnt_val  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_enable) begin
                    data_d   = wr_data;
                    rs_d     = wr_rs;
                    nib_d    = wr_nibble;
                    lcd_rs_d = wr_rs;
                    lcd_d_d  = wr_data[7:4];
                    busy_d   = 1'b1;
                    state_d  = ST_SETUP_H;
                    cnt_load = 1'b1;
                    cnt_val  = LD_SETUP;
                end
            end
            ST_SETUP_H: begin
                if (cnt_done) begin
                    state_d  = ST_PULSE_H;
                    cnt_load = 1'b1;
                    cnt_val  = LD_PULSE;
                end
            end
            ST_PULSE_H: begin
                if (cnt_done) begin
                    state_d  = ST_HOLD_H;
                    cnt_load = 1'b1;
                    cnt_val  = LD_HOLD;
                end
            end
            ST_HOLD_H: begin
                if (cnt_done) begin
                    cnt_load = 1'b1;
                    if (nib_q) begin
                        state_d = ST_EXEC;
                        cnt_val = exec_val;
                    end else begin
                        state_d = ST_GAP;
                        cnt_val = LD_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_done) begin
                    state_d  = ST_SETUP_L;
                    lcd_d_d  = data_q[3:0];
                    cnt_load = 1'b1;
                    cnt_val  = LD_SETUP;
                end
            end
            ST_SETUP_L: begin
                if (cnt_done) begin
                    state_d  = ST_PULSE_L;
                    cnt_load = 1'b1;
                    cnt_val  = LD_PULSE;
                end
            end
            ST_PULSE_L: begin
                if (cnt_done) begin
                    state_d  = ST_HOLD_L;
                    cnt_load = 1'b1;
                    cnt_val  = LD_HOLD;
                end
            end
            ST_HOLD_L: begin
                if (cnt_done) begin
                    state_d  = ST_EXEC;
                    cnt_load = 1'b1;
                    cnt_val  = exec_val;
                end
            end
            ST_EXEC: begin
                if (cnt_done) begin
                    state_d = ST_DONE;
                    fin_d   = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // E is a registered decode of the state being entered.
        lcd_e_d = (state_d == ST_PULSE_H) || (state_d == ST_PULSE_L);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            rs_q     <= 1'b0;
            nib_q    <= 1'b0;
            lcd_d_q  <= '0;
            lcd_rs_q <= 1'b0;
            lcd_e_q  <= 1'b0;
            busy_q   <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            nib_q    <= nib_d;
            lcd_d_q  <= lcd_d_d;
            lcd_rs_q <= lcd_rs_d;
            lcd_e_q  <= lcd_e_d;
            busy_q   <= busy_d;
            fin_q    <= fin_d;
        end
    end

    assign wr_finish = fin_q;
    assign busy      = busy_q;
    assign lcd_d     = lcd_d_q;
    assign lcd_e     = lcd_e_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = 1'b0;

endmodule

// File: doc/lcd_write_ctrl.md
Name: lcd_write_ctrl

Overview:
- Physical write engine for the HD44780-compatible character LCD in 4-bit mode; sits directly downstream of the LCD init/refresh sequencer.
- Accepts a one-cycle write request carrying a byte (or single nibble) and RS.
- Generates the nibble/E-strobe timing on the LCD pins.
- Returns a one-cycle wr_finish once the controller's execution time has elapsed.

Parameters:
T_SETUP, 2, cycles RS/data stable before E rises (40 ns at 50 MHz)
T_PULSE, 12, cycles E held high (>=230 ns)
T_HOLD, 1, cycles data held after E falls
T_GAP, 50, cycles between upper and lower nibble (1 us)
T_EXEC, 2000, cycles post-write wait for normal commands/data (40 us)
T_EXEC_LONG, 82000, cycles post-write wait for Clear (0x01) / Home (0x02) (1.64 ms)
CNT_W, 17, delay counter width; must hold T_EXEC_LONG

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-high reset
wr_enable  in  1  write request pulse; sampled only in IDLE
wr_data  in  8  byte to write; upper nibble first
wr_rs  in  1  0 = command, 1 = data
wr_nibble  in  1  1 = send upper nibble of wr_data only (init-sequence writes)
wr_finish  out  1  one-cycle pulse when the write and its execution wait are complete
busy  out  1  high from the capture edge until the wr_finish cycle inclusive
lcd_d  out  4  LCD data bus D7..D4
lcd_e  out  1  LCD enable strobe
lcd_rs  out  1  LCD register select
lcd_rw  out  1  LCD read/write; constant 0 (write only)

Behaviour:
- Reset: asynchronous, active-high on rst, clock clk. All outputs are registered.
- Reset values: wr_finish=0, busy=0, lcd_d=0, lcd_e=0, lcd_rs=0, lcd_rw=0. FSM goes to IDLE and the delay counter clears.
- States: IDLE, SETUP_H, PULSE_H, HOLD_H, GAP, SETUP_L, PULSE_L, HOLD_L, EXEC, DONE.
- Capture:
  - In IDLE with wr_enable=1 at edge k, latch wr_data, wr_rs and wr_nibble.
  - Drive lcd_rs=wr_rs and lcd_d=wr_data[7:4], set busy=1, and enter SETUP_H.
- Phase durations: each timed state lasts exactly its parameter's cycle count. The counter loads N-1 on entry and the state exits when the counter reaches 0.
- Strobe: lcd_e=1 only in PULSE_H/PULSE_L, for exactly T_PULSE cycles per nibble. lcd_d and lcd_rs are stable through SETUP, PULSE and HOLD.
- Transitions:
  - SETUP_H -> PULSE_H -> HOLD_H.
  - HOLD_H -> EXEC if latched nibble=1, else -> GAP.
  - GAP -> SETUP_L, which drives lcd_d=data[3:0] on entry.
  - SETUP_L -> PULSE_L -> HOLD_L -> EXEC.
- EXEC length:
  - T_EXEC_LONG when latched rs=0 and data is 0x01 or 0x02 (nibble mode excluded).
  - Otherwise T_EXEC.
- EXEC -> DONE. DONE asserts wr_finish for exactly one cycle, then returns to IDLE with busy=0.
- Latency (defaults, byte write, capture edge k):
  - lcd_e high in cycles k+2 .. k+13 and k+67 .. k+78.
  - wr_finish high in the single cycle following edge k+2080.
  - Nibble write: wr_finish after edge k+2015.
- wr_enable outside IDLE (including the DONE cycle) is ignored; it is neither queued nor allowed to corrupt latched data. wr_data/wr_rs changes after capture have no effect.
- lcd_d holds its last value in IDLE/EXEC; lcd_e=0 in every non-PULSE state.
- Reset mid-write: lcd_e drops to 0 immediately (asynchronously). No wr_finish is generated for the aborted write. The upstream sequencer, also reset, restarts initialisation.
- Counter never wraps: it loads only on state entry and decrements only when nonzero.

Decomposition:
- Shared package lcd_pkg:
  - state encoding typedef;
  - default timing constants (T_* at 50 MHz);
  - command codes CMD_CLEAR=8'h01 and CMD_HOME=8'h02, shared with the init/refresh sequencer and the init ROM.
- One natural sub-module: lcd_delay_cnt.
  - CNT_W-bit loadable down-counter.
  - Ports: clk, rst, load, load_val, done.
  - Instantiated once and reused by all timed states.

Test Plan:
- Byte write: rst 3 cycles, then wr_enable pulse with wr_data=8'h48, wr_rs=1.
  - lcd_rs=1 throughout.
  - lcd_d=4'h4 during the first E pulse (12 cycles) and 4'h8 during the second.
  - 50-cycle gap between pulses; exactly one wr_finish 2080 cycles after capture; busy high until then.
- Long command: wr_data=8'h01, wr_rs=0.
  - wr_finish arrives 82000+80 cycles after capture.
  - Repeat with 8'h02 (same long wait) and 8'h06 (normal 2080-cycle wait).
- Nibble mode: wr_nibble=1, wr_data=8'h30, wr_rs=0.
  - Single E pulse with lcd_d=4'h3, no second pulse.
  - wr_finish 2015 cycles after capture.
- Back-to-back and ignored requests:
  - wr_enable pulsed during the GAP and DONE cycles: no extra E pulses, no change to the latched byte.
  - wr_enable in the cycle after wr_finish starts a new write.
- Reset mid-operation: assert rst during PULSE_L.
  - lcd_e falls the same cycle; all outputs at reset values; no wr_finish.
  - A subsequent write completes normally.
- Upstream integration: connect to the init/refresh sequencer with lcd_cnt=2'd3.
  - Exactly 4 wr_enable/wr_finish handshakes, each wr_enable issued only while busy=0.
